// File: rtl/pmem_responder_pkg.sv
// pmem_responder_pkg: shared line/mask types, widths and responder states
package pmem_responder_pkg;
  localparam int LINE_W = 128;
  localparam int MASK_W = 16;
  localparam int ADR_W = 12;
  localparam int CNT_W = 4;
  typedef logic [LINE_W-1:0] lc3b_line;
  typedef logic [MASK_W-1:0] lc3b_line_mask;
  typedef enum logic [1:0] {INIT, IDLE, BUSY, RESP} pmem_resp_state_t;
endpackage

// File: rtl/pmem_line_array.sv
// pmem_line_array: line store with byte-masked write, clear port and registered read
module pmem_line_array
  import pmem_responder_pkg::*;
#(
  parameter int DEPTH_LOG2 = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr_i,
  input  logic [DEPTH_LOG2-1:0] clr_idx_i,
  input  logic                  wr_en_i,
  input  logic [DEPTH_LOG2-1:0] wr_idx_i,
  input  lc3b_line_mask         wr_sel_i,
  input  lc3b_line              wr_data_i,
  input  logic                  rd_en_i,
  input  logic [DEPTH_LOG2-1:0] rd_idx_i,
  output lc3b_line              rd_data_o
);
  lc3b_line mem [2**DEPTH_LOG2];
  lc3b_line rd_q;
  // Clear has priority; otherwise commit only the enabled bytes
  always_ff @(posedge clk) begin
    if (clr_i) mem[clr_idx_i] <= '0;
    else if (wr_en_i)
      for (int b = 0; b < MASK_W; b++)
        if (wr_sel_i[b]) mem[wr_idx_i][b*8 +: 8] <= wr_data_i[b*8 +: 8];
  end
  // Read register holds the last line read until the next read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_q <= '0;
    else if (rd_en_i) rd_q <= mem[rd_idx_i];
  end
  assign rd_data_o = rd_q;
endmodule

// File: rtl/pmem_responder.sv
// pmem_responder: Wishbone line memory slave with programmable read/write latency
module pmem_responder
  import pmem_responder_pkg::*;
#(
  parameter int DEPTH_LOG2    = 8,
  parameter int READ_LATENCY  = 4,
  parameter int WRITE_LATENCY = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [ADR_W-1:0] wb_adr_i,
  input  lc3b_line         wb_dat_i,
  output lc3b_line         wb_dat_o,
  input  lc3b_line_mask    wb_sel_i,
  input  logic             wb_cyc_i,
  input  logic             wb_stb_i,
  input  logic             wb_we_i,
  output logic             wb_ack_o,
  output logic             wb_rty_o
);
  localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(READ_LATENCY - 1);
  localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WRITE_LATENCY - 1);
  pmem_resp_state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, load;
  logic [DEPTH_LOG2-1:0] init_q, init_d, adr_q, rd_idx;
  logic we_q, ack_q, req, latch, rd_we;
  lc3b_line_mask sel_q;
  lc3b_line dat_q;
  logic unused_adr;
  assign unused_adr = ^wb_adr_i[ADR_W-1:DEPTH_LOG2];
  assign req = wb_cyc_i & wb_stb_i;
  assign load = wb_we_i ? WR_LOAD : RD_LOAD;
  // Next-state: sweep the array clear, accept, count down (aborting on a dropped strobe), respond once
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    init_d = init_q;
    latch = 1'b0;
    case (state_q)
      INIT: begin
        init_d = init_q + 1'b1;
        state_d = &init_q ? IDLE : INIT;
      end
      IDLE: if (req) begin
        latch = 1'b1;
        cnt_d = load;
        state_d = load == '0 ? RESP : BUSY;
      end
      BUSY: begin
        cnt_d = cnt_q - 1'b1;
        state_d = !req ? IDLE : (cnt_q == CNT_W'(1) ? RESP : BUSY);
      end
      default: state_d = IDLE;
    endcase
  end
  // A zero-latency-1 read enters RESP straight from IDLE, so it reads from the live bus fields
  assign rd_we = latch ? wb_we_i : we_q;
  assign rd_idx = latch ? wb_adr_i[DEPTH_LOG2-1:0] : adr_q;
  // State, counter, request latch and ACK register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= INIT;
      cnt_q <= '0;
      init_q <= '0;
      adr_q <= '0;
      we_q <= 1'b0;
      sel_q <= '0;
      dat_q <= '0;
      ack_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      init_q <= init_d;
      ack_q <= state_d == RESP;
      if (latch) begin
        adr_q <= wb_adr_i[DEPTH_LOG2-1:0];
        we_q <= wb_we_i;
        sel_q <= wb_sel_i;
        dat_q <= wb_dat_i;
      end
    end
  end
  pmem_line_array #(.DEPTH_LOG2(DEPTH_LOG2)) u_array (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     (state_q == INIT),
    .clr_idx_i (init_q),
    .wr_en_i   (state_q == RESP && we_q),
    .wr_idx_i  (adr_q),
    .wr_sel_i  (sel_q),
    .wr_data_i (dat_q),
    .rd_en_i   (state_d == RESP && !rd_we),
    .rd_idx_i  (rd_idx),
    .rd_data_o (wb_dat_o)
  );
  assign wb_ack_o = ack_q;
  assign wb_rty_o = 1'b0;
endmodule

// File: tb/tb_pmem_responder.sv
// tb_pmem_responder: randomized and directed checks of two latency configurations against a line model
module tb_pmem_responder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [11:0] adr [2];
  logic [127:0] dat_m [2];
  logic [127:0] dat_s [2];
  logic [15:0] sel [2];
  logic cyc [2];
  logic stb [2];
  logic we [2];
  logic ack [2];
  logic rty [2];
  logic [127:0] model [2][256];
  logic [127:0] last_rd [2];
  int lr [2] = '{4, 1};
  int lw [2] = '{4, 7};
  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pmem_responder #(.DEPTH_LOG2(8), .READ_LATENCY(4), .WRITE_LATENCY(4)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .wb_adr_i(adr[0]), .wb_dat_i(dat_m[0]), .wb_dat_o(dat_s[0]),
    .wb_sel_i(sel[0]), .wb_cyc_i(cyc[0]), .wb_stb_i(stb[0]), .wb_we_i(we[0]),
    .wb_ack_o(ack[0]), .wb_rty_o(rty[0]));

  pmem_responder #(.DEPTH_LOG2(8), .READ_LATENCY(1), .WRITE_LATENCY(7)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .wb_adr_i(adr[1]), .wb_dat_i(dat_m[1]), .wb_dat_o(dat_s[1]),
    .wb_sel_i(sel[1]), .wb_cyc_i(cyc[1]), .wb_stb_i(stb[1]), .wb_we_i(we[1]),
    .wb_ack_o(ack[1]), .wb_rty_o(rty[1]));

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] merge(input logic [127:0] old, input logic [127:0] nw, input logic [15:0] s);
    logic [127:0] r = old;
    for (int b = 0; b < 16; b++) if (s[b]) r[b*8 +: 8] = nw[b*8 +: 8];
    return r;
  endfunction

  task automatic clear_model();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 256; i++) model[d][i] = '0;
      last_rd[d] = '0;
    end
  endtask

  task automatic access(input int d, input bit w, input logic [11:0] a, input logic [15:0] s,
                        input logic [127:0] wd, input string tag, output logic [127:0] rd);
    int lat = w ? lw[d] : lr[d];
    int first = -1;
    int acks = 0;
    rd = 'x;
    @(negedge clk);
    cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = w; adr[d] = a; sel[d] = s; dat_m[d] = wd;
    for (int k = 1; k <= lat + 4; k++) begin
      @(negedge clk);
      if (ack[d]) begin
        acks++;
        if (first < 0) begin first = k; rd = dat_s[d]; end
        cyc[d] = 1'b0; stb[d] = 1'b0;
      end else if (stb[d]) begin
        adr[d] = 12'($urandom); sel[d] = 16'($urandom); we[d] = ~w;
        dat_m[d] = {$urandom, $urandom, $urandom, $urandom};
      end
    end
    cyc[d] = 1'b0; stb[d] = 1'b0;
    check({tag, " ack_cycle"}, 128'(first), 128'(lat));
    check({tag, " ack_count"}, 128'(acks), 128'd1);
    if (w) begin
      check({tag, " dat_s_hold"}, rd, last_rd[d]);
      model[d][a[7:0]] = merge(model[d][a[7:0]], wd, s);
    end else begin
      check({tag, " rdata"}, rd, model[d][a[7:0]]);
      last_rd[d] = model[d][a[7:0]];
    end
  endtask

  task automatic wait_init();
    int first [2] = '{-1, -1};
    int acks [2] = '{0, 0};
    logic [127:0] rd [2];
    for (int d = 0; d < 2; d++) begin
      cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = 1'b0; adr[d] = 12'($urandom); sel[d] = '1;
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 1; n <= 300; n++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) if (ack[d]) begin
        acks[d]++;
        if (first[d] < 0) begin first[d] = n; rd[d] = dat_s[d]; end
        cyc[d] = 1'b0; stb[d] = 1'b0;
      end
    end
    for (int d = 0; d < 2; d++) begin
      cyc[d] = 1'b0; stb[d] = 1'b0;
      check($sformatf("init%0d first_ack", d), 128'(first[d]), 128'(256 + lr[d]));
      check($sformatf("init%0d ack_count", d), 128'(acks[d]), 128'd1);
      check($sformatf("init%0d cleared", d), rd[d], 128'd0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [127:0] rd, wd;
    logic [11:0] a;
    logic [15:0] s;
    logic [9:0] pat;
    int acks;
    bit w;
    for (int d = 0; d < 2; d++) begin
      cyc[d] = 0; stb[d] = 0; we[d] = 0; adr[d] = '0; sel[d] = '0; dat_m[d] = '0;
    end
    clear_model();
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("reset%0d ack", d), 128'(ack[d]), 128'd0);
      check($sformatf("reset%0d rty", d), 128'(rty[d]), 128'd0);
      check($sformatf("reset%0d dat_s", d), dat_s[d], 128'd0);
    end
    wait_init();

    access(0, 1, 12'h010, 16'hFFFF, 128'h0123456789ABCDEF0123456789ABCDEF, "wr010", rd);
    access(0, 0, 12'h010, 16'h0000, '0, "rd010", rd);
    check("rd010 const", rd, 128'h0123456789ABCDEF0123456789ABCDEF);
    access(0, 1, 12'h020, 16'hFFFF, '1, "wr020_ones", rd);
    access(0, 1, 12'h020, 16'h00F0, '0, "wr020_mask", rd);
    access(0, 0, 12'h020, 16'h1234, '0, "rd020", rd);
    check("rd020 const", rd, 128'hFFFFFFFF_FFFFFFFF_00000000_FFFFFFFF);
    access(0, 1, 12'h020, 16'h0000, '0, "wr020_sel0", rd);
    access(0, 0, 12'h020, 16'h0000, '0, "rd020_sel0", rd);
    access(0, 1, 12'h105, 16'hFFFF, {16{8'hA5}}, "wr105", rd);
    access(0, 0, 12'h005, 16'h0000, '0, "rd005", rd);
    check("alias const", rd, {16{8'hA5}});

    @(negedge clk);
    cyc[0] = 1; stb[0] = 1; we[0] = 1; adr[0] = 12'h030; sel[0] = '1; dat_m[0] = '1;
    acks = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (ack[0]) acks++;
      if (k == 2) stb[0] = 0;
    end
    cyc[0] = 0;
    check("abort ack_count", 128'(acks), 128'd0);
    access(0, 0, 12'h030, 16'h0000, '0, "rd030", rd);
    check("abort const", rd, 128'd0);

    access(1, 1, 12'h0AB, 16'hFFFF, {4{32'hDEADBEEF}}, "d1_wr", rd);
    access(1, 0, 12'h0AB, 16'h0000, '0, "d1_rd", rd);
    @(negedge clk);
    cyc[1] = 1; stb[1] = 1; we[1] = 0; adr[1] = 12'h0AB;
    pat = '0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      pat[k-1] = ack[1];
      if (k == 10) begin cyc[1] = 0; stb[1] = 0; end
    end
    check("b2b pattern", 128'(pat), 128'(10'b0101010101));
    check("b2b no_consecutive", 128'(pat & (pat >> 1)), 128'd0);
    check("b2b rdata", dat_s[1], {4{32'hDEADBEEF}});
    repeat (2) @(negedge clk);

    for (int i = 0; i < 40; i++) begin
      for (int d = 0; d < 2; d++) begin
        w = 1'($urandom);
        a = 12'($urandom) & 12'hF07;
        case ($urandom_range(0, 3))
          0: s = '0;
          1: s = '1;
          default: s = 16'($urandom);
        endcase
        wd = {$urandom, $urandom, $urandom, $urandom};
        access(d, w, a, s, wd, $sformatf("rnd%0d_%0d", d, i), rd);
      end
    end

    access(0, 0, 12'h010, 16'h0000, '0, "pre_reset_rd", rd);
    @(negedge clk);
    cyc[0] = 1; stb[0] = 1; we[0] = 1; adr[0] = 12'h040; sel[0] = '1; dat_m[0] = {4{32'h5A5A_1234}};
    for (int k = 1; k <= 3; k++) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst ack", 128'(ack[0]), 128'd0);
    check("midrst dat_s", dat_s[0], 128'd0);
    check("midrst rty", 128'(rty[0]), 128'd0);
    clear_model();
    repeat (2) @(negedge clk);
    check("midrst held ack", 128'(ack[0]), 128'd0);
    wait_init();
    access(0, 0, 12'h040, 16'h0000, '0, "rd040_after_rst", rd);
    check("rd040 const", rd, 128'd0);
    check("final rty", 128'(rty[0] | rty[1]), 128'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/pmem_responder.md
# pmem_responder

Wishbone slave that terminates the physical-memory bus driven by the processor top level. It accepts 128-bit line reads and byte-masked line writes and serves them from an internal line array. Each access completes after a programmable latency. It serves as the synthesizable memory endpoint for full-system simulation, and as the reference responder against which the interconnect, eviction and stream buffers are verified.

## Interface
Parameters:
- DEPTH_LOG2, 8, log2 of the number of 128-bit lines held; ADR bits above this are ignored (address aliases).
- READ_LATENCY, 4, cycles from request acceptance to ACK for reads; legal range 1..15.
- WRITE_LATENCY, 4, the same for writes; legal range 1..15.

Ports:
- clk  in  1  clock; must be the same net as wb.CLK.
- rst_n  in  1  reset; one clock, reset is asynchronous and active-low.
- wb  wishbone.slave  interface bundle, carrying:
  - ADR in 12: line address.
  - DAT_M in 128: write data.
  - DAT_S out 128: read data.
  - SEL in 16: byte enables.
  - CYC in 1, STB in 1, WE in 1: request qualifiers and direction.
  - ACK out 1: completion.
  - RTY out 1: retry.

## Operation
- States: IDLE, BUSY, RESP.
- **IDLE:**
  - If CYC & STB, latch ADR[DEPTH_LOG2-1:0], WE, SEL and DAT_M into request registers.
  - Load the counter with (WE ? WRITE_LATENCY : READ_LATENCY) - 1.
  - Go to RESP if the loaded value is 0, else go to BUSY.
- **BUSY:**
  - Decrement the counter each cycle; go to RESP when it reaches 0.
  - If CYC or STB drops, abort: return to IDLE with no ACK and no array write.
- **RESP:**
  - ACK = 1 for exactly this cycle, then return to IDLE.
  - Write: at the RESP clock edge, update bytes i where latched SEL[i] = 1; bytes with SEL[i] = 0 are unchanged.
  - Read: DAT_S carries the array line at the latched address during the RESP cycle. It is registered when entering RESP and holds its value afterwards until the next read response.
- All request fields are taken from the latched copy. Master changes to ADR/DAT_M/SEL/WE after acceptance have no effect.
- RTY is tied to 0. The responder never retries.
- Read-after-write to the same line returns the written data, since the write commits before any later request can be accepted.
- SEL = 0 on a write: the access still completes with ACK, and the array is unchanged.
- SEL is ignored on reads; the full line is always returned.

## Timing
- Call the request-accept cycle (IDLE with CYC & STB high) cycle 0. ACK is high in cycle LAT only.
- A new request can be accepted in the cycle after RESP at the earliest. Back-to-back throughput is one access per LAT+1 cycles.
- If STB is still high in the cycle after ACK, it is treated as a new request. Masters must drop STB after sampling ACK.
- Reset (rst_n low, any time, including mid-BUSY or RESP):
  - State is forced to IDLE.
  - ACK, RTY and DAT_S are forced to 0.
  - The counter and request registers are cleared.
  - An in-flight write is discarded; the array is not written.
- The array is cleared to zero by reset. For the parameterized depth, this uses a sequential clear on deassertion: a 2^DEPTH_LOG2-cycle INIT state ahead of IDLE, during which requests are not accepted and ACK stays 0.
- Invariant: ACK is never high on two consecutive cycles.

## Structure
- lc3b_types gains:
  - lc3b_line (logic [127:0]).
  - lc3b_line_mask (logic [15:0]).
  - pmem_resp_state_t enum {INIT, IDLE, BUSY, RESP}.
- Sub-module pmem_line_array:
  - Synchronous byte-masked write port and registered read port, each with index DEPTH_LOG2 bits wide.
  - Clear port is driven by the INIT counter.
- pmem_responder holds the FSM, latency counter, request latch and output registers.

## Test plan
- Reset then idle: after rst_n rises, expect 256 INIT cycles with ACK=0. Then write ADR=0x010, SEL=0xFFFF, DAT_M=0x0123…CDEF (LAT 4) -> ACK only in cycle 4. Reading ADR=0x010 returns the same line in its ACK cycle.
- Byte mask: write all-ones to ADR 0x020, then write 0 with SEL=0x00F0 -> a read returns 0xFFFF…_FFFF_0000_0000_FFFF_FFFF; only bytes 4..7 are zero.
- Aliasing: write 0xA5…A5 to ADR 0x105 -> a read of ADR 0x005 returns 0xA5…A5.
- Abort: drop STB in cycle 2 of a write to ADR 0x030 -> no ACK is ever raised, and a later read of 0x030 returns 0.
- Latency parameters: set READ_LATENCY=1, WRITE_LATENCY=7. A read must ACK in cycle 1 and a write in cycle 7. Back-to-back reads must ACK every 2 cycles, and ACK is never high on consecutive cycles.
- Reset mid-operation: assert rst_n low in cycle 3 of a write to 0x040 -> ACK and DAT_S go to 0 immediately. After INIT, a read of 0x040 returns 0.
